// File: rtl/dbg_pkg.sv
// Shared types and constants for the register-file dump path.
package dbg_pkg;

    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned REC_BYTES  = 5;
    localparam int unsigned REC_W      = REC_BYTES * BYTE_W;
    // Zero padding above the address in byte 0 of a record (default build)
    localparam int unsigned ADDR_PAD_W = BYTE_W - DEF_ADDR_W;
    // Wide enough to count REC_BYTES down to zero
    localparam int unsigned BIDX_W     = 3;
    // Settle counter width; SETTLE_CYC is limited to 1..15
    localparam int unsigned SCNT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SEND,
        ST_DONE
    } state_e;

endpackage

// File: rtl/regfile_dump_ctrl_if.sv
// Byte stream carrying dump records towards the UART/LED debug path.
//   dump_data  : stream byte
//   dump_valid : byte valid
//   dump_ready : downstream accepts the byte
interface regfile_dump_ctrl_if;
    import dbg_pkg::*;

    logic [BYTE_W-1:0] dump_data;
    logic              dump_valid;
    logic              dump_ready;

    modport master (output dump_data, output dump_valid, input dump_ready);
    modport slave  (input  dump_data, input  dump_valid, output dump_ready);

endinterface

// File: rtl/byte_serializer.sv
// Emits a loaded 40-bit record LSB byte first under valid/ready.
//   clk, rst_n     : clock, async active-low reset
//   load_i         : load rec_i and start emitting (only used while idle)
//   rec_i          : record, byte 0 in bits [7:0]
//   flush_i        : drop the record immediately (abort); beats load and transfer
//   ready_i        : downstream ready
//   valid_o/data_o : registered stream outputs
//   last_xfer_c_o  : combinational, final byte is transferring this cycle
module byte_serializer
    import dbg_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [REC_W-1:0]  rec_i,
    input  logic              flush_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [BYTE_W-1:0] data_o,
    output logic              last_xfer_c_o
);

    logic [REC_W-1:0]  sh_q, sh_d;
    logic [BIDX_W-1:0] cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              xfer_c;

    assign xfer_c        = valid_q & ready_i;
    assign last_xfer_c_o = xfer_c & ~flush_i & (cnt_q == BIDX_W'(1));
    assign valid_o       = valid_q;
    assign data_o        = sh_q[BYTE_W-1:0];

    // Next-state: flush > load > shift on handshake
    always_comb begin
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (flush_i) begin
            sh_d    = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else if (load_i) begin
            sh_d    = rec_i;
            cnt_d   = BIDX_W'(REC_BYTES);
            valid_d = 1'b1;
        end else if (xfer_c) begin
            // Shifting in zeros leaves data_o at 0 once the record is drained
            sh_d    = sh_q >> BYTE_W;
            cnt_d   = cnt_q - BIDX_W'(1);
            valid_d = (cnt_q != BIDX_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Sweeps the register-file probe address over [first,last] and streams one
// 5-byte record {addr, value LSB..MSB} per register.
//   SYS_clk, SYS_reset    : clock, async active-low reset
//   dump_start/dump_abort : start pulse (ignored while busy), abort level
//   first_reg/last_reg    : range, sampled on accepted start (clamped)
//   reg_addr/reg_value    : probe address out, probe value in
//   dump_if               : record byte stream (master)
//   busy/done             : dump in progress, completion pulse
module regfile_dump_ctrl
    import dbg_pkg::*;
#(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic                 SYS_clk,
    input  logic                 SYS_reset,
    input  logic                 dump_start,
    input  logic                 dump_abort,
    input  logic [ADDR_W-1:0]    first_reg,
    input  logic [ADDR_W-1:0]    last_reg,
    output logic [ADDR_W-1:0]    reg_addr,
    input  logic [DATA_W-1:0]    reg_value,
    regfile_dump_ctrl_if.master  dump_if,
    output logic                 busy,
    output logic                 done
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [SCNT_W-1:0]   settle_q, settle_d;
    logic                busy_q, done_q;
    logic                load_c, flush_c, last_xfer_c;
    logic [REC_W-1:0]    rec_c;

    function automatic logic [ADDR_W-1:0] clamp_reg(input logic [ADDR_W-1:0] r);
        if (32'(r) >= NUM_REGS) return ADDR_W'(NUM_REGS - 1);
        return r;
    endfunction

    assign rec_c    = REC_W'({reg_value, BYTE_W'(addr_q)});
    assign reg_addr = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;

    byte_serializer u_ser (
        .clk           (SYS_clk),
        .rst_n         (SYS_reset),
        .load_i        (load_c),
        .rec_i         (rec_c),
        .flush_i       (flush_c),
        .ready_i       (dump_if.dump_ready),
        .valid_o       (dump_if.dump_valid),
        .data_o        (dump_if.dump_data),
        .last_xfer_c_o (last_xfer_c)
    );

    // Next-state and sequencing; abort beats everything outside IDLE
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        last_d   = last_q;
        settle_d = settle_q;
        load_c   = 1'b0;
        flush_c  = 1'b0;
        if (dump_abort && state_q != ST_IDLE) begin
            state_d  = ST_IDLE;
            addr_d   = '0;
            settle_d = '0;
            flush_c  = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (dump_start && !dump_abort) begin
                        state_d  = ST_SETTLE;
                        addr_d   = clamp_reg(first_reg);
                        last_d   = clamp_reg(last_reg);
                        settle_d = '0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == SCNT_W'(SETTLE_CYC - 1)) begin
                        load_c   = 1'b1;
                        state_d  = ST_SEND;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + SCNT_W'(1);
                    end
                end
                ST_SEND: begin
                    if (last_xfer_c) begin
                        if (addr_q == last_q) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_SETTLE;
                            addr_d  = (addr_q == ADDR_W'(NUM_REGS - 1)) ? '0
                                                                         : addr_q + ADDR_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            last_q   <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            last_q   <= last_d;
            settle_q <= settle_d;
            busy_q   <= (state_d == ST_SETTLE) || (state_d == ST_SEND);
            done_q   <= (state_d == ST_DONE);
        end
    end

endmodule
